// File: rtl/uart_tx_param_if.sv
// rtl/uart_tx_param_if.sv - send/din request and busy/done/tx_out status bundle for uart_tx_param
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 send;
  logic [DATA_BITS-1:0] din;
  logic                 busy;
  logic                 done;
  logic                 tx_out;

  modport master (output send, output din, input busy, input done, input tx_out);
  modport slave  (input send, input din, output busy, output done, output tx_out);
endinterface

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter (start, LSB-first data, optional parity, 1/2 stop bits)
module uart_tx_param #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 1,
  parameter int STOP_BITS     = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_param_if.slave bus
);
  localparam int BAUD_DIV = CLK_FREQUENCY / BAUD_RATE;
  localparam int TW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW       = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 tx_q, tx_d;
  logic                 bit_end;
  logic                 last_stop;
  logic                 parity_bit;

  assign bit_end    = (timer_q == TW'(BAUD_DIV - 1));
  assign last_stop  = (stop_cnt_q == 1'(STOP_BITS - 1));
  // Parity comes from the latched copy so later din changes cannot leak in.
  assign parity_bit = (^data_q) ^ (PARITY_MODE == 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      data_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    if (state_q == S_IDLE || state_q == S_DONE || bit_end) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (bus.send) begin
          shift_d   = bus.din;
          data_d    = bus.din;
          bit_cnt_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
            stop_cnt_d = 1'b0;
            state_d    = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            // A send level still present here must not start a second frame.
            state_d = bus.send ? S_DONE : S_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!bus.send) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_bit;
      default:  tx_d = 1'b1;
    endcase
    bus.busy = (state_q != S_IDLE);
    bus.done = (state_q == S_STOP) && bit_end && last_stop;
  end

  assign bus.tx_out = tx_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - randomized self-checking bench for uart_tx_param against a frame-level bit model
module tb_uart_tx_param;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_b = 1'b1;
  logic       send_r [4];
  logic [8:0] din_r  [4];
  logic       tx_w   [4];
  logic       busy_w [4];
  logic       done_w [4];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_BITS(8)) if0 ();
  uart_tx_param_if #(.DATA_BITS(7)) if1 ();
  uart_tx_param_if #(.DATA_BITS(8)) if2 ();
  uart_tx_param_if #(.DATA_BITS(8)) if3 ();

  uart_tx_param u_def (.clk(clk), .rst(rst), .bus(if0));
  uart_tx_param #(.CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                  .PARITY_MODE(2), .STOP_BITS(2)) u_a (.clk(clk), .rst(rst), .bus(if1));
  uart_tx_param #(.CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                  .PARITY_MODE(1), .STOP_BITS(1)) u_b (.clk(clk), .rst(rst_b), .bus(if2));
  uart_tx_param #(.CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                  .PARITY_MODE(0), .STOP_BITS(1)) u_c (.clk(clk), .rst(rst), .bus(if3));

  assign if0.send = send_r[0];  assign if0.din = din_r[0][7:0];
  assign if1.send = send_r[1];  assign if1.din = din_r[1][6:0];
  assign if2.send = send_r[2];  assign if2.din = din_r[2][7:0];
  assign if3.send = send_r[3];  assign if3.din = din_r[3][7:0];
  assign tx_w[0] = if0.tx_out;  assign busy_w[0] = if0.busy;  assign done_w[0] = if0.done;
  assign tx_w[1] = if1.tx_out;  assign busy_w[1] = if1.busy;  assign done_w[1] = if1.done;
  assign tx_w[2] = if2.tx_out;  assign busy_w[2] = if2.busy;  assign done_w[2] = if2.done;
  assign tx_w[3] = if3.tx_out;  assign busy_w[3] = if3.busy;  assign done_w[3] = if3.done;

  // Caller has just driven send=1 and din at a negedge; the frame occupies the next
  // frame-length cycles. Line levels are built from the frame rules, not the RTL.
  task automatic check_frame(input int sel, input string name, input int div, input int nbits,
                             input int par, input int stops, input logic [8:0] data,
                             input int hold, input int blip_at, input int blip_len);
    int exp_bits[$];
    int pc, frame, i, tx_ones, busy_ones, done_cnt, done_idx;
    exp_bits = {};
    pc = 0;
    exp_bits.push_back(0);
    for (int j = 0; j < nbits; j++) begin
      exp_bits.push_back(int'(data[j]));
      pc += int'(data[j]);
    end
    if (par != 0) exp_bits.push_back((pc % 2) ^ ((par == 2) ? 1 : 0));
    for (int j = 0; j < stops; j++) exp_bits.push_back(1);
    frame = exp_bits.size() * div;
    i = 0;
    done_cnt = 0;
    done_idx = -1;
    for (int b = 0; b < exp_bits.size(); b++) begin
      tx_ones = 0;
      busy_ones = 0;
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        send_r[sel] = (i < hold - 1) || (i >= blip_at && i < blip_at + blip_len);
        if (i == 2) din_r[sel] = 9'($urandom);
        tx_ones   += int'(tx_w[sel]);
        busy_ones += int'(busy_w[sel]);
        if (done_w[sel]) begin
          done_cnt++;
          done_idx = i;
        end
        i++;
      end
      n_vec++;
      if (tx_ones !== exp_bits[b] * div) begin
        n_err++;
        $display("FAIL %s tx bit%0d: got %0d high cycles, want %0d", name, b, tx_ones, exp_bits[b] * div);
      end
      n_vec++;
      if (busy_ones !== div) begin
        n_err++;
        $display("FAIL %s busy bit%0d: got %0d busy cycles, want %0d", name, b, busy_ones, div);
      end
    end
    n_vec++;
    if (done_cnt !== 1 || done_idx !== frame - 1) begin
      n_err++;
      $display("FAIL %s done: got %0d pulses last at %0d, want 1 at %0d", name, done_cnt, done_idx, frame - 1);
    end
  endtask

  task automatic expect_idle(input int sel, input string name);
    @(negedge clk);
    n_vec++;
    if (busy_w[sel] !== 1'b0 || tx_w[sel] !== 1'b1) begin
      n_err++;
      $display("FAIL %s idle: got busy=%b tx=%b, want busy=0 tx=1", name, busy_w[sel], tx_w[sel]);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      n_vec++;
      if (tx_w[s] !== 1'b1 || busy_w[s] !== 1'b0 || done_w[s] !== 1'b0) begin
        n_err++;
        $display("FAIL reset dut%0d: got tx=%b busy=%b done=%b, want 1/0/0", s, tx_w[s], busy_w[s], done_w[s]);
      end
    end
    rst = 1'b0;
    rst_b = 1'b0;
    for (int s = 0; s < 4; s++) expect_idle(s, "post_reset");
  endtask

  task automatic test_default_a5;
    send_r[0] = 1'b1;
    din_r[0] = 9'h0A5;
    check_frame(0, "def_a5", 5208, 8, 1, 1, 9'h0A5, 1, -1, 0);
    expect_idle(0, "def_a5");
  endtask

  task automatic test_odd_7bit;
    logic [8:0] d;
    send_r[1] = 1'b1;
    din_r[1] = 9'h041;
    check_frame(1, "odd7_41", 10, 7, 2, 2, 9'h041, 1, -1, 0);
    expect_idle(1, "odd7_41");
    for (int k = 0; k < 5; k++) begin
      d = 9'($urandom_range(0, 127));
      send_r[1] = 1'b1;
      din_r[1] = d;
      check_frame(1, "odd7_rand", 10, 7, 2, 2, d, 1, -1, 0);
      expect_idle(1, "odd7_rand");
    end
  endtask

  task automatic test_hold;
    int b1, t1, d1;
    logic [8:0] d;
    d = 9'($urandom_range(0, 255));
    send_r[2] = 1'b1;
    din_r[2] = d;
    check_frame(2, "hold", 10, 8, 1, 1, d, 100000, -1, 0);
    b1 = 0; t1 = 0; d1 = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      b1 += int'(busy_w[2]);
      t1 += int'(tx_w[2]);
      d1 += int'(done_w[2]);
    end
    n_vec++;
    if (b1 !== 60 || t1 !== 60 || d1 !== 0) begin
      n_err++;
      $display("FAIL hold_done: got busy=%0d tx=%0d done=%0d of 60, want 60/60/0", b1, t1, d1);
    end
    send_r[2] = 1'b0;
    expect_idle(2, "hold_release");
    t1 = 0; b1 = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      t1 += int'(tx_w[2]);
      b1 += int'(busy_w[2]);
    end
    n_vec++;
    if (t1 !== 20 || b1 !== 0) begin
      n_err++;
      $display("FAIL hold_no_second: got tx=%0d busy=%0d of 20, want 20/0", t1, b1);
    end
    d = 9'($urandom_range(0, 255));
    send_r[2] = 1'b1;
    din_r[2] = d;
    check_frame(2, "hold_second", 10, 8, 1, 1, d, 1, -1, 0);
    expect_idle(2, "hold_second");
  endtask

  task automatic test_reset_midframe;
    int dcnt;
    send_r[2] = 1'b1;
    din_r[2] = 9'h000;
    @(negedge clk);
    send_r[2] = 1'b0;
    repeat (42) @(negedge clk);
    n_vec++;
    if (tx_w[2] !== 1'b0 || busy_w[2] !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre: got tx=%b busy=%b, want 0/1", tx_w[2], busy_w[2]);
    end
    #2 rst_b = 1'b1;
    #1;
    n_vec++;
    if (tx_w[2] !== 1'b1 || busy_w[2] !== 1'b0) begin
      n_err++;
      $display("FAIL rst_async: got tx=%b busy=%b, want 1/0", tx_w[2], busy_w[2]);
    end
    dcnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      dcnt += int'(done_w[2]);
    end
    rst_b = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      dcnt += int'(done_w[2]);
    end
    n_vec++;
    if (dcnt !== 0 || tx_w[2] !== 1'b1 || busy_w[2] !== 1'b0) begin
      n_err++;
      $display("FAIL rst_after: got done=%0d tx=%b busy=%b, want 0/1/0", dcnt, tx_w[2], busy_w[2]);
    end
    send_r[2] = 1'b1;
    din_r[2] = 9'h03C;
    check_frame(2, "rst_3c", 10, 8, 1, 1, 9'h03C, 1, -1, 0);
    expect_idle(2, "rst_3c");
  endtask

  task automatic test_back_to_back;
    send_r[3] = 1'b1;
    din_r[3] = 9'h000;
    check_frame(3, "b2b_00", 10, 8, 0, 1, 9'h000, 1, -1, 0);
    expect_idle(3, "b2b_gap");
    send_r[3] = 1'b1;
    din_r[3] = 9'h0FF;
    check_frame(3, "b2b_ff", 10, 8, 0, 1, 9'h0FF, 1, -1, 0);
    expect_idle(3, "b2b_ff");
  endtask

  task automatic test_send_while_busy;
    logic [8:0] d;
    for (int k = 0; k < 6; k++) begin
      d = 9'($urandom_range(0, 255));
      send_r[2] = 1'b1;
      din_r[2] = d;
      check_frame(2, "busy_send", 10, 8, 1, 1, d, 1, $urandom_range(3, 80), $urandom_range(1, 8));
      expect_idle(2, "busy_send");
    end
  endtask

  initial begin
    for (int s = 0; s < 4; s++) begin
      send_r[s] = 1'b0;
      din_r[s]  = '0;
    end
    test_reset();
    test_default_a5();
    test_odd_7bit();
    test_hold();
    test_reset_midframe();
    test_back_to_back();
    test_send_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter: serialises one DATA_BITS-wide word per `send` request into an asynchronous frame. The frame is a start bit, LSB-first data, optional even/odd parity, and one or two stop bits. It drives the chip-level `tx_out` pin and is the generalised successor to the fixed 8N1 transmitter. Frame format and bit rate are fixed at elaboration by parameters.

## Interface
- CLK_FREQUENCY, 100_000_000: clock frequency in Hz.
- BAUD_RATE, 19_200: line bit rate in bits/s.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY_MODE, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.
- clk  input  1  system clock; the only clock in the block.
- rst  input  1  reset, asynchronous, active-high.
- send  input  1  transmit request; level-sensitive, sampled only in IDLE.
- din  input  DATA_BITS  word to send; captured on the accepting edge.
- busy  output  1  high from the accepting edge until the return to IDLE.
- done  output  1  one-cycle pulse at the end of the last stop bit.
- tx_out  output  1  serial line; registered; idles high.

## Operation
- BAUD_DIV = CLK_FREQUENCY / BAUD_RATE, integer truncation (5208 at defaults). Every bit lasts exactly BAUD_DIV cycles.
- Bit timer counts 0..BAUD_DIV-1. It is held at 0 in IDLE and DONE and wraps at the end of each bit. Timer width is clog2(BAUD_DIV).
- States are IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE: on `send`=1, latch `din` into the shift register, clear the bit counter, go to START.
  - START: tx_out=0 for one bit, then DATA.
  - DATA: tx_out = shift register LSB. Shift right at each bit end. After DATA_BITS bits go to PARITY, or to STOP when PARITY_MODE=0.
  - PARITY: tx_out = XOR of the latched data for even parity, inverted XOR for odd. Lasts one bit, then STOP.
  - STOP: tx_out=1 for STOP_BITS bits. At the last bit end, pulse `done`. Then go to DONE if `send`=1, else IDLE.
  - DONE: tx_out=1, busy=1. Go to IDLE on the first cycle with `send`=0.
- The bit counter width is clog2(DATA_BITS+1). The stop counter is 1 bit.
- Parity is computed from the latched copy, never from the live `din`.
- Changes to `din` after acceptance are ignored.
- `send` high while busy is ignored; it never starts, queues or restarts a frame.
- Because of DONE, one continuous `send` level produces exactly one frame.

## Timing
- Reset values: tx_out=1, busy=0, done=0, state IDLE, timer=0, counters=0.
- Reset takes effect asynchronously, including mid-frame: tx_out returns high immediately with no partial stop bit. The first action after reset release is IDLE sampling.
- Latency: `send` is sampled high at edge k. At edge k, tx_out goes 0 and busy goes 1, so both are visible in cycle k+1.
- Frame length is FRAME = (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) × BAUD_DIV cycles. At defaults this is 11 × 5208 = 57288 cycles.
- `done` is high for the single cycle where the stop-phase timer is at BAUD_DIV-1 on the last stop bit. It is the same edge that leaves STOP.
- busy falls at the edge that enters IDLE: the STOP exit edge, or the DONE exit edge when `send` is held.
- The earliest next start bit begins 1 cycle after IDLE is entered. There is no other inter-frame gap.
- `send` and the end of the last stop bit in the same cycle: go to DONE, not to a new frame.

## Test plan
- Defaults, din=8'hA5, `send` pulsed for 1 cycle:
  - tx_out reads 0, 1,0,1,0,0,1,0,1, 0 (even parity), 1, each level for 5208 cycles.
  - `done` pulses at cycle 57288 after acceptance; busy drops on the same edge.
- DATA_BITS=7, PARITY_MODE=2, STOP_BITS=2, CLK_FREQUENCY=1_000_000, BAUD_RATE=100_000, din=7'h41:
  - tx_out reads 0, 1,0,0,0,0,0,1, 1 (odd parity), 1,1, each for 10 cycles; frame is 110 cycles.
- `send` held high for 200000 cycles, `din` changed mid-frame:
  - Exactly one frame carrying the originally latched value.
  - busy stays high through DONE and falls 1 cycle after `send` drops.
  - A second frame starts only after `send` re-asserts.
- rst pulsed during data bit 3:
  - tx_out=1 and busy=0 without waiting for a clock edge; `done` never pulses.
  - The next `send` of 8'h3C produces a clean, full-length frame.
- PARITY_MODE=0, CLK_FREQUENCY=1_000_000, BAUD_RATE=100_000, frames 8'h00 then 8'hFF, `send` re-asserted the cycle after IDLE:
  - Two 100-cycle frames with no parity bit.
  - Second start bit begins 1 cycle after busy falls.
- `send` asserted while busy in mid-frame:
  - Ignored; no extra frame and no glitch on tx_out.
